// File: rtl/matrix_alu_sequencer_pkg.sv
// Shared definitions for the matrix ALU sequencer: data widths, ALU opcodes, FSM encoding.
package matrix_alu_sequencer_pkg;

  localparam int unsigned MATRIX_W = 256;
  localparam int unsigned ELEM_W   = 4;
  localparam int unsigned OP_W     = 4;

  // Opcodes of the combinational `arithmetic` ALU
  localparam logic [OP_W-1:0] OP_MUL = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_SDC = 4'd3;
  localparam logic [OP_W-1:0] OP_SRR = 4'd4;
  localparam logic [OP_W-1:0] OP_SUC = 4'd5;
  localparam logic [OP_W-1:0] OP_SLR = 4'd6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_MUL, OP_ADD, OP_SUB, OP_SDC, OP_SRR, OP_SUC, OP_SLR: op_legal = 1'b1;
      default:                                                op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/matrix_regfile.sv
// Matrix register file: one write port, two operand read ports and a host read port.
module matrix_regfile
  import matrix_alu_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned AW       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [MATRIX_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr1_i,
  input  logic [AW-1:0]       raddr2_i,
  input  logic [AW-1:0]       haddr_i,
  output logic [MATRIX_W-1:0] rdata1_o,
  output logic [MATRIX_W-1:0] rdata2_o,
  output logic [MATRIX_W-1:0] hrdata_o
);

  logic [MATRIX_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
  assign hrdata_o = regs_q[haddr_i];

endmodule

// File: rtl/matrix_alu_sequencer.sv
// Multi-cycle controller for the combinational 8x8x4-bit matrix ALU: fetches operands from
// the register file, waits the ALU settle time and writes the result back.
module matrix_alu_sequencer
  import matrix_alu_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned AW       = 2,
  parameter int unsigned EXEC_LAT = 1,
  parameter int unsigned MUL_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_opcode,
  input  logic [AW-1:0]       instr_src1,
  input  logic [AW-1:0]       instr_src2,
  input  logic [AW-1:0]       instr_dst,
  input  logic                host_we,
  input  logic [AW-1:0]       host_addr,
  input  logic [MATRIX_W-1:0] host_wdata,
  output logic [MATRIX_W-1:0] host_rdata,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [MATRIX_W-1:0] alu_matrix1,
  output logic [MATRIX_W-1:0] alu_matrix2,
  input  logic [MATRIX_W-1:0] alu_matrixr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned MAX_LAT = (MUL_LAT > EXEC_LAT) ? MUL_LAT : EXEC_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [AW-1:0]       src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
  logic [MATRIX_W-1:0] m1_q, m1_d, m2_q, m2_d, res_q, res_d;

  logic                accept;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [MATRIX_W-1:0] rf_wdata, rd1, rd2;

  assign accept = instr_valid && instr_ready;

  // Single write port: a host write always takes precedence over the write-back
  assign rf_we    = host_we || (state_q == ST_WRITE);
  assign rf_waddr = host_we ? host_addr  : dst_q;
  assign rf_wdata = host_we ? host_wdata : res_q;

  matrix_regfile #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (src1_q),
    .raddr2_i (src2_q),
    .haddr_i  (host_addr),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .hrdata_o (host_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      alu_op_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      alu_op_q <= alu_op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      dst_q    <= dst_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    alu_op_d = alu_op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dst_d    = dst_q;
    m1_d     = m1_q;
    m2_d     = m2_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = instr_opcode;
          src1_d  = instr_src1;
          src2_d  = instr_src2;
          dst_d   = instr_dst;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        m1_d     = rd1;
        m2_d     = rd2;
        alu_op_d = op_q;
        cnt_d    = (op_q == OP_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(EXEC_LAT);
        state_d  = op_legal(op_q) ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          res_d   = alu_matrixr;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (!host_we) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE) && !host_we;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_WRITE) && !host_we;
  assign err         = (state_q == ST_READ) && !op_legal(op_q);
  assign alu_opcode  = alu_op_q;
  assign alu_matrix1 = m1_q;
  assign alu_matrix2 = m2_q;

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Scoreboard bench for matrix_alu_sequencer with a behavioural ALU and register-file model.
module tb_matrix_alu_sequencer;
  import matrix_alu_sequencer_pkg::*;

  localparam int EXEC_L = 1;
  localparam int MUL_L  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [3:0]   instr_opcode = '0;
  logic [1:0]   instr_src1 = '0, instr_src2 = '0, instr_dst = '0;
  logic         host_we = 1'b0;
  logic [1:0]   host_addr = '0;
  logic [255:0] host_wdata = '0;
  logic [255:0] host_rdata;
  logic [3:0]   alu_opcode;
  logic [255:0] alu_matrix1, alu_matrix2, alu_matrixr;
  logic         busy, done, err;

  typedef struct {
    bit           is_err;
    int           cyc;
    logic [255:0] res;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  logic [255:0] mdl [4];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  matrix_alu_sequencer #(
    .NUM_REGS (4),
    .AW       (2),
    .EXEC_LAT (EXEC_L),
    .MUL_LAT  (MUL_L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_src1   (instr_src1),
    .instr_src2   (instr_src2),
    .instr_dst    (instr_dst),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .alu_opcode   (alu_opcode),
    .alu_matrix1  (alu_matrix1),
    .alu_matrix2  (alu_matrix2),
    .alu_matrixr  (alu_matrixr),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Element (r,c) of an 8x8 matrix of 4-bit values, row-major from bit 0
  function automatic int el(input logic [255:0] m, input int r, input int c);
    return int'(m[(r*8+c)*4 +: 4]);
  endfunction

  function automatic logic [255:0] alu_model(input logic [3:0] op, input logic [255:0] a,
                                             input logic [255:0] b);
    logic [255:0] o;
    int s;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (op)
          OP_MUL: begin
            s = 0;
            for (int k = 0; k < 8; k++) s += el(a, r, k) * el(b, k, c);
          end
          OP_ADD:  s = el(a, r, c) + el(b, r, c);
          OP_SUB:  s = el(a, r, c) - el(b, r, c);
          OP_SDC:  s = el(a, (r + 7) % 8, c);
          OP_SUC:  s = el(a, (r + 1) % 8, c);
          OP_SRR:  s = el(a, r, (c + 7) % 8);
          OP_SLR:  s = el(a, r, (c + 1) % 8);
          default: s = 0;
        endcase
        o[(r*8+c)*4 +: 4] = 4'(s);
      end
    end
    return o;
  endfunction

  assign alu_matrixr = alu_model(alu_opcode, alu_matrix1, alu_matrix2);

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] fill(input logic [3:0] x);
    logic [255:0] v;
    for (int i = 0; i < 64; i++) v[i*4 +: 4] = x;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [255:0] d);
    @(negedge clk);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    mdl[a] = d;
    #1 check("ready_low_during_host_we", 256'(instr_ready), 256'(0));
    @(posedge clk);
    #1 host_we = 1'b0;
  endtask

  task automatic check_all();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      host_addr = 2'(i);
      #1 check($sformatf("reg%0d", i), host_rdata, mdl[i]);
    end
  endtask

  task automatic expect_reg(input string name, input logic [1:0] a, input logic [255:0] v);
    @(negedge clk);
    host_addr = a;
    #1 check(name, host_rdata, v);
  endtask

  // Issue one instruction; hold>0 keeps host_we high for that many WRITE cycles (aimed at dst)
  task automatic issue(input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [1:0] d, input int hold);
    exp_t e;
    int acc, lat, nb;
    bit legal;
    logic [255:0] r;
    legal = (op <= 4'd6);
    lat = (op == OP_MUL) ? MUL_L : EXEC_L;
    r = alu_model(op, mdl[s1], mdl[s2]);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_opcode = op;
    instr_src1 = s1;
    instr_src2 = s2;
    instr_dst = d;
    #1 check("instr_ready_idle", 256'(instr_ready), 256'(1));
    @(posedge clk);
    #1 acc = cyc;
    e.is_err = !legal;
    e.cyc = legal ? acc + 1 + lat + hold : acc;
    e.res = r;
    sbq.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0;
    nb = 0;
    for (int p = 0; p < 64; p++) begin
      host_we = legal && (hold > 0) && (p >= 1 + lat) && (p < 1 + lat + hold);
      if (host_we) begin
        host_addr = d;
        host_wdata = rand256();
        mdl[d] = host_wdata;
      end
      #1;
      if (!busy) break;
      nb++;
      @(negedge clk);
    end
    host_we = 1'b0;
    check("busy_cycles", 256'(nb), legal ? 256'(2 + lat + hold) : 256'(1));
    check("ready_after_op", 256'(instr_ready), 256'(1));
    if (legal) mdl[d] = r;
    check_all();
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (done || err) begin
        if (sbq.size() == 0) begin
          check("unexpected_done_err", {254'b0, done, err}, 256'(0));
        end else begin
          mon_e = sbq.pop_front();
          check("event_kind", {254'b0, done, err}, mon_e.is_err ? 256'(1) : 256'(2));
          check("event_cycle", 256'(cyc), 256'(mon_e.cyc));
          if (!mon_e.is_err) check("alu_result_at_done", alu_matrixr, mon_e.res);
        end
      end
    end
  end

  initial begin
    logic [255:0] ident, a, t;
    logic [3:0] op;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 256'(instr_ready), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_alu_opcode", 256'(alu_opcode), 256'(0));
    check("rst_alu_m1", alu_matrix1, 256'(0));
    check("rst_alu_m2", alu_matrix2, 256'(0));
    check_all();

    // ADD and SUB wrap
    host_write(2'd0, fill(4'h1));
    host_write(2'd1, fill(4'h2));
    issue(OP_ADD, 2'd0, 2'd1, 2'd2, 0);
    expect_reg("add_r2", 2'd2, {64{4'h3}});
    host_write(2'd0, fill(4'h0));
    host_write(2'd1, fill(4'h1));
    issue(OP_SUB, 2'd0, 2'd1, 2'd3, 0);
    expect_reg("sub_wrap_r3", 2'd3, {64{4'hF}});

    // Identity times A into an aliased destination
    ident = '0;
    for (int i = 0; i < 8; i++) ident[(i*8+i)*4 +: 4] = 4'h1;
    a = rand256();
    host_write(2'd0, ident);
    host_write(2'd1, a);
    issue(OP_MUL, 2'd0, 2'd1, 2'd0, 0);
    expect_reg("mul_identity_r0", 2'd0, a);

    // Shift round trips on a row/column-tagged matrix
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) t[(r*8+c)*4 +: 4] = 4'(r * 5 + c * 3);
    host_write(2'd0, t);
    issue(OP_SDC, 2'd0, 2'd3, 2'd1, 0);
    issue(OP_SUC, 2'd1, 2'd0, 2'd2, 0);
    expect_reg("sdc_suc_roundtrip", 2'd2, t);
    issue(OP_SLR, 2'd0, 2'd2, 2'd1, 0);
    issue(OP_SRR, 2'd1, 2'd0, 2'd3, 0);
    expect_reg("slr_srr_roundtrip", 2'd3, t);

    // Illegal opcode and host collision during WRITE
    issue(4'hF, 2'd0, 2'd1, 2'd2, 0);
    issue(OP_ADD, 2'd2, 2'd3, 2'd1, 2);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) host_write(2'($urandom_range(0, 3)), rand256());
      op = 4'($urandom_range(0, 9));
      issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            (op <= 4'd6) ? $urandom_range(0, 2) : 0);
    end

    // Reset in the middle of a MUL: no done, register file cleared
    @(negedge clk);
    instr_valid = 1'b1;
    instr_opcode = OP_MUL;
    instr_src1 = 2'd0;
    instr_src2 = 2'd1;
    instr_dst = 2'd2;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    #1;
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_ready", 256'(instr_ready), 256'(1));
    repeat (4) @(negedge clk);
    check_all();

    check("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
